// File: rtl/ice_mem_arb.sv
// ice_mem_arb: two-requester (CPU / ICE) memory arbiter with round-robin tie
// break, memory timeout, and a debug halt/single-step gate on CPU grants.
module ice_mem_arb #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_ACK,
  input  logic          ICE_REQ,
  input  logic          ICE_WE,
  input  logic [AW-1:0] ICE_ADDR,
  input  logic [DW-1:0] ICE_WDATA,
  output logic          ICE_ACK,
  output logic [DW-1:0] RDATA,
  output logic          ERR,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic          MEM_READY,
  input  logic          CORE_HALT,
  input  logic          STEP,
  output logic          HALTED
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        state_q;
  logic          owner_cpu_q;
  logic          last_cpu_q;
  logic          step_tok_q;
  logic [CW-1:0] tmo_cnt_q;

  logic cpu_elig_c;
  logic grant_c;
  logic grant_cpu_c;
  logic cpu_hold_c;
  logic tmo_hit_c;

  // Grant decision and whether the CPU will own the port after this edge
  always_comb begin
    cpu_elig_c  = CPU_REQ && (!CORE_HALT || step_tok_q);
    grant_c     = (state_q == S_IDLE) && (ICE_REQ || cpu_elig_c);
    grant_cpu_c = cpu_elig_c && (!ICE_REQ || !last_cpu_q);
    tmo_hit_c   = (tmo_cnt_q == TMO_LAST);
    cpu_hold_c  = 1'b0;
    case (state_q)
      S_IDLE:   cpu_hold_c = grant_c && grant_cpu_c;
      S_ACCESS: cpu_hold_c = owner_cpu_q;
      default:  cpu_hold_c = 1'b0;
    endcase
  end

  // Arbiter FSM, memory strobes, response and halt/step bookkeeping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      owner_cpu_q <= 1'b0;
      last_cpu_q  <= 1'b1;
      step_tok_q  <= 1'b0;
      tmo_cnt_q   <= '0;
      CPU_ACK     <= 1'b0;
      ICE_ACK     <= 1'b0;
      RDATA       <= '0;
      ERR         <= 1'b0;
      MEM_EN      <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
      HALTED      <= 1'b0;
    end else begin
      CPU_ACK <= 1'b0;
      ICE_ACK <= 1'b0;
      HALTED  <= CORE_HALT && !cpu_hold_c;

      // Step token: one CPU grant while halted; dropped on resume or use
      if (!CORE_HALT) begin
        step_tok_q <= 1'b0;
      end else if (grant_c && grant_cpu_c) begin
        step_tok_q <= 1'b0;
      end else if (STEP) begin
        step_tok_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_c) begin
            state_q     <= S_ACCESS;
            owner_cpu_q <= grant_cpu_c;
            last_cpu_q  <= grant_cpu_c;
            tmo_cnt_q   <= '0;
            MEM_EN      <= 1'b1;
            MEM_WE      <= grant_cpu_c ? CPU_WE    : ICE_WE;
            MEM_ADDR    <= grant_cpu_c ? CPU_ADDR  : ICE_ADDR;
            MEM_WDATA   <= grant_cpu_c ? CPU_WDATA : ICE_WDATA;
          end
        end
        S_ACCESS: begin
          if (MEM_READY || tmo_hit_c) begin
            state_q <= S_RESP;
            MEM_EN  <= 1'b0;
            MEM_WE  <= 1'b0;
            CPU_ACK <= owner_cpu_q;
            ICE_ACK <= !owner_cpu_q;
            RDATA   <= MEM_READY ? MEM_RDATA : '0;
            ERR     <= !MEM_READY;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ice_mem_arb.sv
// Bench for ice_mem_arb: directed scenarios with literal expectations plus
// randomized traffic, all checked cycle by cycle against a transaction model.
module tb_ice_mem_arb;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CPU_REQ = 1'b0, CPU_WE = 1'b0;
  logic [AW-1:0] CPU_ADDR = '0;
  logic [DW-1:0] CPU_WDATA = '0;
  logic          ICE_REQ = 1'b0, ICE_WE = 1'b0;
  logic [AW-1:0] ICE_ADDR = '0;
  logic [DW-1:0] ICE_WDATA = '0;
  logic [DW-1:0] MEM_RDATA = '0;
  logic          MEM_READY = 1'b0;
  logic          CORE_HALT = 1'b0;
  logic          STEP = 1'b0;
  logic          CPU_ACK, ICE_ACK, ERR, MEM_EN, MEM_WE, HALTED;
  logic [DW-1:0] RDATA, MEM_WDATA;
  logic [AW-1:0] MEM_ADDR;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ice_mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA), .CPU_ACK(CPU_ACK),
    .ICE_REQ(ICE_REQ), .ICE_WE(ICE_WE), .ICE_ADDR(ICE_ADDR), .ICE_WDATA(ICE_WDATA), .ICE_ACK(ICE_ACK),
    .RDATA(RDATA), .ERR(ERR), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
    .CORE_HALT(CORE_HALT), .STEP(STEP), .HALTED(HALTED)
  );

  // Transaction-level model: one access in flight, then a one-cycle response
  bit            m_busy, m_resp, m_cpu, m_we, m_last_cpu, m_tok, m_halted, m_err;
  int            m_wait;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  function automatic void model_reset();
    m_busy = 0; m_resp = 0; m_cpu = 0; m_we = 0; m_last_cpu = 1;
    m_tok = 0; m_halted = 0; m_err = 0; m_wait = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endfunction

  function automatic void model_step();
    bit ice_ok, cpu_ok, give_cpu, granted;
    granted = 0; give_cpu = 0;
    if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      m_wait++;
      if (MEM_READY) begin
        m_rdata = MEM_RDATA; m_err = 0; m_busy = 0; m_resp = 1;
      end else if (m_wait == int'(TO)) begin
        m_rdata = '0; m_err = 1; m_busy = 0; m_resp = 1;
      end
    end else begin
      ice_ok = ICE_REQ;
      cpu_ok = CPU_REQ && (!CORE_HALT || m_tok);
      if (ice_ok || cpu_ok) begin
        granted  = 1;
        give_cpu = cpu_ok && (!ice_ok || !m_last_cpu);
        m_cpu = give_cpu; m_last_cpu = give_cpu; m_busy = 1; m_wait = 0;
        m_we    = give_cpu ? CPU_WE    : ICE_WE;
        m_addr  = give_cpu ? CPU_ADDR  : ICE_ADDR;
        m_wdata = give_cpu ? CPU_WDATA : ICE_WDATA;
      end
    end
    if (!CORE_HALT) m_tok = 0;
    else if (granted && give_cpu) m_tok = 0;
    else if (STEP) m_tok = 1;
    m_halted = CORE_HALT && !((m_busy || m_resp) && m_cpu);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("cpu_ack",   32'(CPU_ACK),   32'(m_resp && m_cpu));
    check("ice_ack",   32'(ICE_ACK),   32'(m_resp && !m_cpu));
    check("mem_en",    32'(MEM_EN),    32'(m_busy));
    check("mem_we",    32'(MEM_WE),    32'(m_busy && m_we));
    check("mem_addr",  32'(MEM_ADDR),  32'(m_addr));
    check("mem_wdata", 32'(MEM_WDATA), 32'(m_wdata));
    check("halted",    32'(HALTED),    32'(m_halted));
    if (m_resp) begin
      check("rdata", 32'(RDATA), 32'(m_rdata));
      check("err",   32'(ERR),   32'(m_err));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed mid-cycle, held through one edge
  task automatic async_reset_pulse();
    #2 RST = 1'b1;
    #1;
    model_reset();
    check("rst_mem_en_async", 32'(MEM_EN), 32'd0);
    compare_all();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int en_cnt, ack_n, ack_at;
    bit seen, low_seen;

    // Reset state
    #1;
    model_reset();
    compare_all();
    check("rst_rdata", 32'(RDATA), 32'd0);
    check("rst_err",   32'(ERR),   32'd0);
    tick();
    RST = 1'b0;

    // Both requesters reading, memory always ready: ICE, CPU, ICE
    CPU_REQ = 1; ICE_REQ = 1; CPU_ADDR = 16'h0100; ICE_ADDR = 16'h0200;
    MEM_READY = 1; MEM_RDATA = 16'hA5A5;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("rr_ice_ack", 32'(ICE_ACK), 32'(i == 2 || i == 8));
      check("rr_cpu_ack", 32'(CPU_ACK), 32'(i == 5));
      if (i == 8) begin CPU_REQ = 0; ICE_REQ = 0; end
    end

    // ICE write, memory ready on the third access cycle
    MEM_READY = 0; ICE_REQ = 1; ICE_WE = 1; ICE_ADDR = 16'h1234; ICE_WDATA = 16'hBEEF;
    en_cnt = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (MEM_EN) begin
        en_cnt++;
        if (en_cnt == 1) begin
          check("wr_addr",  32'(MEM_ADDR),  32'h1234);
          check("wr_wdata", 32'(MEM_WDATA), 32'hBEEF);
          check("wr_we",    32'(MEM_WE),    32'd1);
        end
        if (en_cnt == 3) MEM_READY = 1;
      end
      if (ICE_ACK) begin
        seen = 1; ICE_REQ = 0; MEM_READY = 0;
        check("wr_en_cycles", 32'(en_cnt), 32'd3);
        check("wr_err", 32'(ERR), 32'd0);
      end
    end
    check("wr_ack_seen", 32'(seen), 32'd1);

    // Timeout: memory never ready
    ICE_REQ = 1; ICE_WE = 0; ICE_ADDR = 16'h0042; MEM_RDATA = 16'h5555;
    en_cnt = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (MEM_EN) en_cnt++;
      if (ICE_ACK) begin
        seen = 1; ICE_REQ = 0;
        check("tmo_en_cycles", 32'(en_cnt), 32'd4);
        check("tmo_err",   32'(ERR),   32'd1);
        check("tmo_rdata", 32'(RDATA), 32'd0);
      end
    end
    check("tmo_ack_seen", 32'(seen), 32'd1);

    // Halted CPU: no grant until a single STEP allows exactly one
    CORE_HALT = 1; CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 16'h0777; MEM_READY = 1;
    ack_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (CPU_ACK) ack_n++;
    end
    check("halt_no_grant", 32'(ack_n), 32'd0);
    check("halt_halted", 32'(HALTED), 32'd1);
    STEP = 1;
    tick();
    STEP = 0;
    low_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CPU_ACK) ack_n++;
      if (!HALTED) low_seen = 1;
    end
    check("step_one_ack", 32'(ack_n), 32'd1);
    check("step_halted_dropped", 32'(low_seen), 32'd1);
    check("step_halted_back", 32'(HALTED), 32'd1);
    CPU_REQ = 0; CORE_HALT = 0; MEM_READY = 0;
    tick();

    // Halt raised during a CPU access
    CPU_REQ = 1; CPU_ADDR = 16'h0999;
    tick();
    CORE_HALT = 1;
    tick();
    check("hmid_halted_busy", 32'(HALTED), 32'd0);
    MEM_READY = 1;
    tick();
    check("hmid_cpu_ack", 32'(CPU_ACK), 32'd1);
    check("hmid_halted_ack", 32'(HALTED), 32'd0);
    CPU_REQ = 0;
    tick();
    check("hmid_halted_after", 32'(HALTED), 32'd1);
    CORE_HALT = 0; MEM_READY = 0;
    tick();

    // Reset in the middle of an access, then normal service
    ICE_REQ = 1; ICE_WE = 0; ICE_ADDR = 16'h0ABC;
    tick();
    check("rmid_en_before", 32'(MEM_EN), 32'd1);
    async_reset_pulse();
    MEM_READY = 1;
    ack_n = 0; ack_at = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (ICE_ACK) begin ack_n++; ack_at = i; ICE_REQ = 0; end
    end
    check("rmid_ack_count", 32'(ack_n), 32'd1);
    check("rmid_ack_at", 32'(ack_at), 32'd2);

    // Randomized traffic against the model
    MEM_READY = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset_pulse();
      end
      if (ICE_ACK) ICE_REQ = 0;
      else if (ICE_REQ && $urandom_range(0, 63) == 0) ICE_REQ = 0;
      else if (!ICE_REQ && $urandom_range(0, 2) == 0) begin
        ICE_REQ = 1; ICE_WE = 1'($urandom); ICE_ADDR = 16'($urandom); ICE_WDATA = 16'($urandom);
      end
      if (CPU_ACK) CPU_REQ = 0;
      else if (CPU_REQ && $urandom_range(0, 63) == 0) CPU_REQ = 0;
      else if (!CPU_REQ && $urandom_range(0, 2) == 0) begin
        CPU_REQ = 1; CPU_WE = 1'($urandom); CPU_ADDR = 16'($urandom); CPU_WDATA = 16'($urandom);
      end
      MEM_READY = ($urandom_range(0, 3) == 0);
      MEM_RDATA = 16'($urandom);
      if ($urandom_range(0, 29) == 0) CORE_HALT = ~CORE_HALT;
      STEP = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
